axonerve_kvs_arbiter: RTL and testbench
=======================================

AXONERVE_KVS_ARBITER -- requirements
Module: axonerve_kvs_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TAG_DEPTH, default 16: maximum outstanding commands; power of two.
REQ-003 I_CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 I_RST  in  1  reset; synchronous, active-high.
REQ-005 I_REQ_VALID  in  N_REQ  per-requester command valid.
REQ-006 O_REQ_READY  out  N_REQ  per-requester accept; a command transfers when VALID and READY are both high.
REQ-007 I_REQ_OP  in  5*N_REQ  per-requester one-hot {UPDATE,SEARCH,READ,WRITE,ERASE}, with ERASE at bit 0.
REQ-008 I_REQ_KEY, I_REQ_MSK  in  128*N_REQ each  key data and mask per requester.
REQ-009 I_REQ_PRI  in  7*N_REQ  priority per requester; I_REQ_VALUE  in  32*N_REQ  value per requester.
REQ-010 O_RSP_VALID  out  N_REQ  one-cycle response strobe to the originating requester.
REQ-011 O_RSP_ENT_ERR, O_RSP_SHIT, O_RSP_MHIT  out  1 each; O_RSP_VALUE  out  32; all shared across requesters and qualified by O_RSP_VALID.
REQ-012 O_KVS_CMD_VALID, O_KVS_ERASE, O_KVS_WRITE, O_KVS_READ, O_KVS_SEARCH, O_KVS_UPDATE  out  1 each  kernel command strobe and op.
REQ-013 O_KVS_KEY, O_KVS_MSK  out  128 each; O_KVS_PRI  out  7; O_KVS_VALUE  out  32  kernel command fields.
REQ-014 I_KVS_READY, I_KVS_WAIT, I_KVS_CMD_FULL  in  1 each  kernel status inputs.
REQ-015 I_KVS_ACK, I_KVS_ENT_ERR, I_KVS_SHIT, I_KVS_MHIT  in  1 each; I_KVS_VALUE  in  32  kernel response.
REQ-016 O_OUTSTANDING  out  log2(TAG_DEPTH)+1  current tag-FIFO occupancy.
REQ-017 O_DROP_CNT  out  8  count of rejected commands; O_ORPHAN  out  1  sticky flag for an unexpected ACK.

Function
REQ-018 can_issue = I_KVS_READY && !I_KVS_WAIT && !I_KVS_CMD_FULL && (O_OUTSTANDING < TAG_DEPTH).
REQ-019 At most one request is granted per cycle; no grant is made while can_issue=0.
REQ-020 Arbitration is round-robin: the search starts at rr_ptr and the lowest index at or after rr_ptr with VALID=1 wins; after a grant, rr_ptr = winner+1 mod N_REQ.
REQ-021 O_REQ_READY is combinational and is high only for the granted index in the grant cycle.
REQ-022 A granted command with a valid op (exactly one of ERASE, WRITE, SEARCH, UPDATE set) is forwarded: in the next cycle O_KVS_CMD_VALID=1 for exactly one cycle, with registered op and fields.
REQ-023 In the grant cycle, the winner index is pushed into the tag FIFO.
REQ-024 A granted command with an invalid op (READ set, zero bits set, or more than one bit set) is consumed but not forwarded; it pushes no tag and O_DROP_CNT increments, saturating at 255.
REQ-025 The kernel returns exactly one I_KVS_ACK per forwarded command, in issue order.
REQ-026 On I_KVS_ACK with the tag FIFO non-empty: pop the head tag; in the next cycle O_RSP_VALID[tag]=1 for one cycle, with the ENT_ERR, SHIT, MHIT and VALUE fields registered from the ACK cycle.
REQ-027 On I_KVS_ACK with the tag FIFO empty: no response is generated, no pop occurs, and O_ORPHAN is set and held until reset.
REQ-028 Push and pop in the same cycle leave O_OUTSTANDING unchanged; neither operation is lost.
REQ-029 The tag FIFO wraps its read and write pointers mod TAG_DEPTH.
REQ-030 While O_OUTSTANDING==TAG_DEPTH, no grant occurs; a pop in that cycle does not enable a same-cycle grant.
REQ-031 O_KVS_* data fields hold their last value when O_KVS_CMD_VALID=0.
REQ-032 O_KVS_READ is never asserted.
REQ-033 Requester data is sampled only in the grant cycle.

Reset
REQ-034 While I_RST=1, all of the following are 0: O_REQ_READY, O_RSP_VALID, all O_RSP_*, O_KVS_CMD_VALID, all O_KVS_* ops and fields, O_OUTSTANDING, O_DROP_CNT, O_ORPHAN, and rr_ptr.
REQ-035 While I_RST=1, the tag FIFO is emptied.
REQ-036 Reset asserted mid-operation discards all outstanding tags; ACKs arriving after reset is released set O_ORPHAN.
REQ-037 The first grant is possible in the first cycle after I_RST is released.

Verification
REQ-038 Requesters 0..3 all hold VALID with SEARCH and can_issue=1 -> grants occur in order 0,1,2,3 on consecutive cycles; the kernel sees 4 one-cycle O_KVS_CMD_VALID strobes starting 1 cycle after the first grant.
REQ-039 Requester 2 issues WRITE, then ACK arrives with VALUE=32'hDEADBEEF and SHIT=1 -> the cycle after the ACK, O_RSP_VALID=4'b0100, O_RSP_VALUE=32'hDEADBEEF, O_RSP_SHIT=1, and O_OUTSTANDING returns to 0.
REQ-040 16 commands issued with no ACK -> the 17th request sees READY=0 and O_OUTSTANDING=16; then an ACK arrives -> the request is granted in the following cycle.
REQ-041 Requester 1 issues READ -> the command is consumed, no O_KVS_CMD_VALID follows, O_DROP_CNT=1, and O_OUTSTANDING=0.
REQ-042 I_KVS_ACK arrives with the tag FIFO empty -> O_RSP_VALID stays 0 and O_ORPHAN=1 until I_RST.
REQ-043 I_KVS_WAIT=1 while requests are pending -> no READY, no O_KVS_CMD_VALID; then WAIT deasserts -> a grant occurs in that same cycle.

Source files
------------

// File: rtl/axonerve_kvs_arbiter.sv
// +-------------------------------------------------------------------------+
// | axonerve_kvs_arbiter: round-robin command arbiter in front of the KVS   |
// | kernel, with an in-order tag FIFO that routes ACKs back to requesters.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module axonerve_kvs_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                          I_CLK,
  input  logic                          I_RST,
  input  logic [N_REQ-1:0]              I_REQ_VALID,
  output logic [N_REQ-1:0]              O_REQ_READY,
  input  logic [5*N_REQ-1:0]            I_REQ_OP,
  input  logic [128*N_REQ-1:0]          I_REQ_KEY,
  input  logic [128*N_REQ-1:0]          I_REQ_MSK,
  input  logic [7*N_REQ-1:0]            I_REQ_PRI,
  input  logic [32*N_REQ-1:0]           I_REQ_VALUE,
  output logic [N_REQ-1:0]              O_RSP_VALID,
  output logic                          O_RSP_ENT_ERR,
  output logic                          O_RSP_SHIT,
  output logic                          O_RSP_MHIT,
  output logic [31:0]                   O_RSP_VALUE,
  output logic                          O_KVS_CMD_VALID,
  output logic                          O_KVS_ERASE,
  output logic                          O_KVS_WRITE,
  output logic                          O_KVS_READ,
  output logic                          O_KVS_SEARCH,
  output logic                          O_KVS_UPDATE,
  output logic [127:0]                  O_KVS_KEY,
  output logic [127:0]                  O_KVS_MSK,
  output logic [6:0]                    O_KVS_PRI,
  output logic [31:0]                   O_KVS_VALUE,
  input  logic                          I_KVS_READY,
  input  logic                          I_KVS_WAIT,
  input  logic                          I_KVS_CMD_FULL,
  input  logic                          I_KVS_ACK,
  input  logic                          I_KVS_ENT_ERR,
  input  logic                          I_KVS_SHIT,
  input  logic                          I_KVS_MHIT,
  input  logic [31:0]                   I_KVS_VALUE,
  output logic [$clog2(TAG_DEPTH):0]    O_OUTSTANDING,
  output logic [7:0]                    O_DROP_CNT,
  output logic                          O_ORPHAN
);

  localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_ptr_w = $clog2(TAG_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(TAG_DEPTH);
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(N_REQ - 1);

  logic [c_idx_w-1:0] r_rr_ptr;
  logic [c_idx_w-1:0] w_winner;
  logic               w_found;
  logic               w_can_issue;
  logic               w_grant;
  logic               w_op_ok;
  logic               w_push;
  logic               w_pop;
  logic [4:0]         w_op;
  logic [127:0]       w_key;
  logic [127:0]       w_msk;
  logic [6:0]         w_pri;
  logic [31:0]        w_value;

  logic [c_idx_w-1:0] r_tag_mem [TAG_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_idx_w-1:0] w_head;
  logic [N_REQ-1:0]   w_head_oh;

  // Two passes give the wrap-around search: indices at/after rr_ptr first, then the rest.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && I_REQ_VALID[j] && (c_idx_w'(j) >= r_rr_ptr)) begin
        w_found  = 1'b1;
        w_winner = c_idx_w'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && I_REQ_VALID[j]) begin
        w_found  = 1'b1;
        w_winner = c_idx_w'(j);
      end
    end
  end

  always_comb begin
    w_op    = '0;
    w_key   = '0;
    w_msk   = '0;
    w_pri   = '0;
    w_value = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (c_idx_w'(j) == w_winner) begin
        w_op    = I_REQ_OP[j*5 +: 5];
        w_key   = I_REQ_KEY[j*128 +: 128];
        w_msk   = I_REQ_MSK[j*128 +: 128];
        w_pri   = I_REQ_PRI[j*7 +: 7];
        w_value = I_REQ_VALUE[j*32 +: 32];
      end
    end
  end

  // The occupancy term uses the registered count, so a pop never frees a slot in its own cycle.
  assign w_can_issue = I_KVS_READY && !I_KVS_WAIT && !I_KVS_CMD_FULL && (r_count < c_full);
  assign w_grant     = !I_RST && w_can_issue && w_found;
  assign w_op_ok     = (w_op == 5'b00001) || (w_op == 5'b00010) ||
                       (w_op == 5'b01000) || (w_op == 5'b10000);
  assign w_push      = w_grant && w_op_ok;
  assign w_pop       = !I_RST && I_KVS_ACK && (r_count != '0);
  assign w_head      = r_tag_mem[r_rd_ptr];

  always_comb begin
    O_REQ_READY = '0;
    if (w_grant) begin
      O_REQ_READY[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_head_oh = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_head_oh[j] = (w_head == c_idx_w'(j));
    end
  end

  assign O_OUTSTANDING = r_count;
  assign O_KVS_READ    = 1'b0;

  always_ff @(posedge I_CLK) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_winner;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_rr_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      O_KVS_CMD_VALID <= 1'b0;
      O_KVS_ERASE     <= 1'b0;
      O_KVS_WRITE     <= 1'b0;
      O_KVS_SEARCH    <= 1'b0;
      O_KVS_UPDATE    <= 1'b0;
      O_KVS_KEY       <= '0;
      O_KVS_MSK       <= '0;
      O_KVS_PRI       <= '0;
      O_KVS_VALUE     <= '0;
      O_RSP_VALID     <= '0;
      O_RSP_ENT_ERR   <= 1'b0;
      O_RSP_SHIT      <= 1'b0;
      O_RSP_MHIT      <= 1'b0;
      O_RSP_VALUE     <= '0;
      O_DROP_CNT      <= '0;
      O_ORPHAN        <= 1'b0;
    end else begin
      O_KVS_CMD_VALID <= w_push;
      if (w_push) begin
        O_KVS_ERASE  <= w_op[0];
        O_KVS_WRITE  <= w_op[1];
        O_KVS_SEARCH <= w_op[3];
        O_KVS_UPDATE <= w_op[4];
        O_KVS_KEY    <= w_key;
        O_KVS_MSK    <= w_msk;
        O_KVS_PRI    <= w_pri;
        O_KVS_VALUE  <= w_value;
        r_wr_ptr     <= r_wr_ptr + 1'b1;
      end
      if (w_grant) begin
        r_rr_ptr <= (w_winner == c_last) ? '0 : w_winner + 1'b1;
      end
      if (w_grant && !w_op_ok && (O_DROP_CNT != 8'hFF)) begin
        O_DROP_CNT <= O_DROP_CNT + 8'd1;
      end
      O_RSP_VALID <= w_pop ? w_head_oh : '0;
      if (w_pop) begin
        O_RSP_ENT_ERR <= I_KVS_ENT_ERR;
        O_RSP_SHIT    <= I_KVS_SHIT;
        O_RSP_MHIT    <= I_KVS_MHIT;
        O_RSP_VALUE   <= I_KVS_VALUE;
        r_rd_ptr      <= r_rd_ptr + 1'b1;
      end
      if (I_KVS_ACK && (r_count == '0)) begin
        O_ORPHAN <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axonerve_kvs_arbiter.sv
// Bench for axonerve_kvs_arbiter: vector table plus hand sequences, with a
// command/response scoreboard and an independent tag-order model.
`default_nettype none

module tb_axonerve_kvs_arbiter;

  localparam int N = 4;
  localparam int D = 16;
  localparam logic [4:0] OP_ERASE  = 5'b00001;
  localparam logic [4:0] OP_WRITE  = 5'b00010;
  localparam logic [4:0] OP_READ   = 5'b00100;
  localparam logic [4:0] OP_SEARCH = 5'b01000;
  localparam logic [4:0] OP_UPDATE = 5'b10000;

  typedef struct packed {
    logic [4:0]   op;
    logic [127:0] key;
    logic [127:0] msk;
    logic [6:0]   pri;
    logic [31:0]  val;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  oh;
    logic        ent_err;
    logic        shit;
    logic        mhit;
    logic [31:0] val;
  } rsp_t;

  typedef struct {
    logic [3:0] valid;
    logic [4:0] op;
    logic       wt;
    logic       full;
    logic [3:0] exp_ready;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_op;
  logic [128*N-1:0] req_key;
  logic [128*N-1:0] req_msk;
  logic [7*N-1:0]  req_pri;
  logic [32*N-1:0] req_value;
  logic [N-1:0]    rsp_valid;
  logic            rsp_ent_err, rsp_shit, rsp_mhit;
  logic [31:0]     rsp_value;
  logic            kvs_cmd_valid, kvs_erase, kvs_write, kvs_read, kvs_search, kvs_update;
  logic [127:0]    kvs_key, kvs_msk;
  logic [6:0]      kvs_pri;
  logic [31:0]     kvs_value;
  logic            kvs_ready, kvs_wait, kvs_full;
  logic            ack, ack_ent_err, ack_shit, ack_mhit;
  logic [31:0]     ack_value;
  logic [4:0]      outstanding;
  logic [7:0]      drop_cnt;
  logic            orphan;

  logic [4:0]   op_a  [N];
  logic [127:0] key_a [N];
  logic [127:0] msk_a [N];
  logic [6:0]   pri_a [N];
  logic [31:0]  val_a [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op[i*5 +: 5]      = op_a[i];
      req_key[i*128 +: 128] = key_a[i];
      req_msk[i*128 +: 128] = msk_a[i];
      req_pri[i*7 +: 7]     = pri_a[i];
      req_value[i*32 +: 32] = val_a[i];
    end
  end

  axonerve_kvs_arbiter #(.N_REQ(N), .TAG_DEPTH(D)) dut (
    .I_CLK(clk), .I_RST(rst),
    .I_REQ_VALID(req_valid), .O_REQ_READY(req_ready), .I_REQ_OP(req_op),
    .I_REQ_KEY(req_key), .I_REQ_MSK(req_msk), .I_REQ_PRI(req_pri), .I_REQ_VALUE(req_value),
    .O_RSP_VALID(rsp_valid), .O_RSP_ENT_ERR(rsp_ent_err), .O_RSP_SHIT(rsp_shit),
    .O_RSP_MHIT(rsp_mhit), .O_RSP_VALUE(rsp_value),
    .O_KVS_CMD_VALID(kvs_cmd_valid), .O_KVS_ERASE(kvs_erase), .O_KVS_WRITE(kvs_write),
    .O_KVS_READ(kvs_read), .O_KVS_SEARCH(kvs_search), .O_KVS_UPDATE(kvs_update),
    .O_KVS_KEY(kvs_key), .O_KVS_MSK(kvs_msk), .O_KVS_PRI(kvs_pri), .O_KVS_VALUE(kvs_value),
    .I_KVS_READY(kvs_ready), .I_KVS_WAIT(kvs_wait), .I_KVS_CMD_FULL(kvs_full),
    .I_KVS_ACK(ack), .I_KVS_ENT_ERR(ack_ent_err), .I_KVS_SHIT(ack_shit),
    .I_KVS_MHIT(ack_mhit), .I_KVS_VALUE(ack_value),
    .O_OUTSTANDING(outstanding), .O_DROP_CNT(drop_cnt), .O_ORPHAN(orphan)
  );

  cmd_t cmdq [$];
  rsp_t rspq [$];
  int   tagq [$];
  cmd_t last_cmd;
  int   exp_drop;
  logic exp_orphan;
  logic cmd_due, rsp_due;
  int   n_checks;
  int   n_fail;
  vec_t tbl [18];

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      key_a[i] = {$urandom, $urandom, $urandom, $urandom};
      msk_a[i] = {$urandom, $urandom, $urandom, $urandom};
      pri_a[i] = 7'($urandom);
      val_a[i] = $urandom;
    end
    ack_value   = $urandom;
    ack_ent_err = 1'($urandom);
    ack_shit    = 1'($urandom);
    ack_mhit    = 1'($urandom);
  endtask

  // One clock: compare at the falling edge, then advance the model with this cycle's inputs.
  task automatic step(input logic [3:0] exp_ready);
    cmd_t c;
    rsp_t r;
    logic [319:0] act_k, exp_k;
    int idx, t;
    @(negedge clk);
    check("outstanding", 320'(outstanding), 320'(tagq.size()));
    check("drop_cnt", 320'(drop_cnt), 320'(exp_drop));
    check("orphan", 320'(orphan), 320'(exp_orphan));
    if (cmd_due) begin
      c = cmdq.pop_front();
      last_cmd = c;
      exp_k = 320'({1'b1, 1'b0, c.op[0], c.op[1], c.op[3], c.op[4], c.key, c.msk, c.pri, c.val});
      act_k = 320'({kvs_cmd_valid, kvs_read, kvs_erase, kvs_write, kvs_search, kvs_update,
                    kvs_key, kvs_msk, kvs_pri, kvs_value});
    end else begin
      exp_k = 320'({1'b0, 1'b0, 4'b0000, last_cmd.key, last_cmd.msk, last_cmd.pri, last_cmd.val});
      act_k = 320'({kvs_cmd_valid, kvs_read, 4'b0000, kvs_key, kvs_msk, kvs_pri, kvs_value});
    end
    check("kvs_cmd", act_k, exp_k);
    if (rsp_due) begin
      r = rspq.pop_front();
      check("rsp", 320'({rsp_valid, rsp_ent_err, rsp_shit, rsp_mhit, rsp_value}), 320'(r));
    end else begin
      check("rsp_valid", 320'(rsp_valid), 320'(0));
    end
    check("req_ready", 320'(req_ready), 320'(exp_ready));

    cmd_due = 1'b0;
    rsp_due = 1'b0;
    if (rst) begin
      tagq.delete();
      cmdq.delete();
      rspq.delete();
      exp_drop   = 0;
      exp_orphan = 1'b0;
      last_cmd   = '0;
    end else begin
      if (ack) begin
        if (tagq.size() > 0) begin
          t = tagq.pop_front();
          rspq.push_back({4'(1 << t), ack_ent_err, ack_shit, ack_mhit, ack_value});
          rsp_due = 1'b1;
        end else begin
          exp_orphan = 1'b1;
        end
      end
      if (exp_ready != 4'b0000) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (exp_ready[i]) idx = i;
        if (op_a[idx] inside {OP_ERASE, OP_WRITE, OP_SEARCH, OP_UPDATE}) begin
          c.op  = op_a[idx];
          c.key = key_a[idx];
          c.msk = msk_a[idx];
          c.pri = pri_a[idx];
          c.val = val_a[idx];
          cmdq.push_back(c);
          tagq.push_back(idx);
          cmd_due = 1'b1;
        end else if (exp_drop < 255) begin
          exp_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    randomize_data();
    ack = 1'b0;
  endtask

  task automatic set_ops(input logic [4:0] op);
    for (int i = 0; i < N; i++) op_a[i] = op;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cmd_due  = 1'b0;
    rsp_due  = 1'b0;
    exp_drop = 0;
    exp_orphan = 1'b0;
    last_cmd = '0;

    tbl[0]  = '{4'b1111, OP_SEARCH, 1'b0, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1111, OP_SEARCH, 1'b0, 1'b0, 4'b0010};
    tbl[2]  = '{4'b1111, OP_SEARCH, 1'b0, 1'b0, 4'b0100};
    tbl[3]  = '{4'b1111, OP_SEARCH, 1'b0, 1'b0, 4'b1000};
    tbl[4]  = '{4'b0101, OP_ERASE,  1'b0, 1'b0, 4'b0001};
    tbl[5]  = '{4'b0101, OP_WRITE,  1'b0, 1'b0, 4'b0100};
    tbl[6]  = '{4'b0101, OP_UPDATE, 1'b0, 1'b0, 4'b0001};
    tbl[7]  = '{4'b1010, OP_SEARCH, 1'b0, 1'b0, 4'b0010};
    tbl[8]  = '{4'b1000, OP_ERASE,  1'b0, 1'b0, 4'b1000};
    tbl[9]  = '{4'b0000, OP_SEARCH, 1'b0, 1'b0, 4'b0000};
    tbl[10] = '{4'b1111, OP_SEARCH, 1'b1, 1'b0, 4'b0000};
    tbl[11] = '{4'b1111, OP_SEARCH, 1'b1, 1'b0, 4'b0000};
    tbl[12] = '{4'b1111, OP_SEARCH, 1'b0, 1'b1, 4'b0000};
    tbl[13] = '{4'b1111, OP_SEARCH, 1'b0, 1'b0, 4'b0001};
    tbl[14] = '{4'b0010, OP_READ,   1'b0, 1'b0, 4'b0010};
    tbl[15] = '{4'b0100, 5'b00000,  1'b0, 1'b0, 4'b0100};
    tbl[16] = '{4'b1000, 5'b00011,  1'b0, 1'b0, 4'b1000};
    tbl[17] = '{4'b0000, OP_SEARCH, 1'b0, 1'b0, 4'b0000};

    rst       = 1'b1;
    req_valid = 4'b1111;
    kvs_ready = 1'b1;
    kvs_wait  = 1'b0;
    kvs_full  = 1'b0;
    ack       = 1'b0;
    set_ops(OP_SEARCH);
    randomize_data();
    repeat (2) @(posedge clk);
    #1;

    // Reset held with every requester asking.
    step(4'b0000);
    step(4'b0000);

    // Vector table; its first row is the first cycle after release.
    rst = 1'b0;
    foreach (tbl[v]) begin
      req_valid = tbl[v].valid;
      set_ops(tbl[v].op);
      kvs_wait  = tbl[v].wt;
      kvs_full  = tbl[v].full;
      step(tbl[v].exp_ready);
    end
    kvs_wait = 1'b0;
    kvs_full = 1'b0;

    // Drain the ten forwarded commands in issue order.
    req_valid = 4'b0000;
    repeat (10) begin
      ack = 1'b1;
      step(4'b0000);
    end
    step(4'b0000);

    // Requester 2 WRITE, ACK with DEADBEEF / SHIT.
    req_valid = 4'b0100;
    op_a[2]   = OP_WRITE;
    step(4'b0100);
    req_valid = 4'b0000;
    step(4'b0000);
    ack = 1'b1; ack_value = 32'hDEADBEEF; ack_shit = 1'b1; ack_mhit = 1'b0; ack_ent_err = 1'b0;
    step(4'b0000);
    step(4'b0000);

    // Fill the tag FIFO, stall at 16, then pop and pop+push.
    req_valid = 4'b1111;
    set_ops(OP_UPDATE);
    for (int k = 0; k < 16; k++) step(4'(1 << ((3 + k) % 4)));
    step(4'b0000);
    ack = 1'b1;
    step(4'b0000);
    ack = 1'b1;
    step(4'b1000);
    req_valid = 4'b0000;
    repeat (15) begin
      ack = 1'b1;
      step(4'b0000);
    end
    step(4'b0000);

    // ACK with nothing outstanding.
    ack = 1'b1;
    step(4'b0000);
    step(4'b0000);
    step(4'b0000);

    // Reset mid-operation; a later ACK finds no tag.
    req_valid = 4'b0011;
    set_ops(OP_SEARCH);
    step(4'b0001);
    step(4'b0010);
    rst = 1'b1;
    step(4'b0000);
    step(4'b0000);
    rst = 1'b0;
    req_valid = 4'b0000;
    step(4'b0000);
    ack = 1'b1;
    step(4'b0000);
    step(4'b0000);
    step(4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
